// File: rtl/cpu_bus_dtack_ctrl.sv
// 68000 /DTACK generator: fixed per-region wait states, ROM req/ack handshake
// with the SDRAM arbiter, and timeout termination of unmapped cycles.
module cpu_bus_dtack_ctrl #(
   parameter int WORK_WAIT     = 1,
   parameter int VIDEO_WAIT    = 2,
   parameter int IO_WAIT       = 1,
   parameter int SOUND_WAIT    = 4,
   parameter int UNMAPPED_WAIT = 8,
   parameter int ROM_TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_as_n,
   input  logic [1:0] cpu_ds_n,
   input  logic       WORKn,
   input  logic       ROMn,
   input  logic       SCREENn,
   input  logic       COLORn,
   input  logic       IOn,
   input  logic       OBJECTn,
   input  logic       SOUNDn,
   input  logic       extension_n,
   input  logic       SS_SAVEn,
   input  logic       SS_RESETn,
   input  logic       SS_VECn,
   output logic       rom_req,
   input  logic       rom_ack,
   output logic       cpu_dtack_n,
   output logic       timeout_err,
   output logic       busy
);

   // DRAIN: strobe released during a ROM cycle; finish the handshake, no DTACK.
   typedef enum logic [2:0] {IDLE, WAIT, ROM, DRAIN, ACK} state_t;

   state_t     state, state_d;
   logic [7:0] cnt, cnt_d;
   logic [7:0] wait_cyc;
   logic       req_d, dtack_d, terr_d, busy_d;
   logic       start;

   assign start = ~cpu_as_n & ~(&cpu_ds_n);

   always_comb begin
      wait_cyc = 8'(UNMAPPED_WAIT);
      if      (!SS_RESETn)   wait_cyc = 8'(WORK_WAIT);
      else if (!SS_VECn)     wait_cyc = 8'(WORK_WAIT);
      else if (!SS_SAVEn)    wait_cyc = 8'(WORK_WAIT);
      else if (!ROMn)        wait_cyc = 8'd0;
      else if (!WORKn)       wait_cyc = 8'(WORK_WAIT);
      else if (!SCREENn)     wait_cyc = 8'(VIDEO_WAIT);
      else if (!OBJECTn)     wait_cyc = 8'(VIDEO_WAIT);
      else if (!COLORn)      wait_cyc = 8'(VIDEO_WAIT);
      else if (!IOn)         wait_cyc = 8'(IO_WAIT);
      else if (!extension_n) wait_cyc = 8'(IO_WAIT);
      else if (!SOUNDn)      wait_cyc = 8'(SOUND_WAIT);
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      req_d   = rom_req;
      dtack_d = cpu_dtack_n;
      terr_d  = timeout_err;
      case (state)
         IDLE: if (start) begin
            // ROMn only wins when no save-state select outranks it
            if (SS_RESETn && SS_VECn && SS_SAVEn && !ROMn) begin
               state_d = ROM;
               cnt_d   = 8'(ROM_TIMEOUT);
               req_d   = 1'b1;
            end else if (wait_cyc == 8'd0) begin
               state_d = ACK;
               dtack_d = 1'b0;
            end else begin
               state_d = WAIT;
               cnt_d   = wait_cyc - 8'd1;
            end
         end
         WAIT: begin
            if (cpu_as_n) state_d = IDLE;
            else if (cnt == 8'd0) begin
               state_d = ACK;
               dtack_d = 1'b0;
            end else cnt_d = cnt - 8'd1;
         end
         ROM, DRAIN: begin
            if (rom_ack || cnt == 8'd0) begin
               req_d = 1'b0;
               if (!rom_ack) terr_d = 1'b1;
               if (state == DRAIN || cpu_as_n) state_d = IDLE;
               else begin
                  state_d = ACK;
                  dtack_d = 1'b0;
               end
            end else begin
               cnt_d = cnt - 8'd1;
               if (cpu_as_n) state_d = DRAIN;
            end
         end
         ACK: if (cpu_as_n) begin
            dtack_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         rom_req     <= 1'b0;
         cpu_dtack_n <= 1'b1;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         rom_req     <= req_d;
         cpu_dtack_n <= dtack_d;
         timeout_err <= terr_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_cpu_bus_dtack_ctrl.sv
// Randomized bus cycles checked against a latency model derived from region
// priority and wait counts, plus directed abort/timeout/reset cases.
module tb_cpu_bus_dtack_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_as_n = 1'b1;
   logic [1:0] cpu_ds_n = 2'b11;
   logic [10:0] sel = '1;
   logic       rom_ack = 1'b0;
   logic       rom_req, cpu_dtack_n, timeout_err, busy;

   int checks = 0;
   int errors = 0;
   bit terr_model = 1'b0;

   always #5 clk = ~clk;

   // sel index = priority rank: 0 SS_RESETn .. 10 SOUNDn
   cpu_bus_dtack_ctrl dut (
      .clk(clk), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_ds_n(cpu_ds_n),
      .SS_RESETn(sel[0]), .SS_VECn(sel[1]), .SS_SAVEn(sel[2]), .ROMn(sel[3]),
      .WORKn(sel[4]), .SCREENn(sel[5]), .OBJECTn(sel[6]), .COLORn(sel[7]),
      .IOn(sel[8]), .extension_n(sel[9]), .SOUNDn(sel[10]),
      .rom_req(rom_req), .rom_ack(rom_ack), .cpu_dtack_n(cpu_dtack_n),
      .timeout_err(timeout_err), .busy(busy)
   );

   int region_wait [11] = '{1, 1, 1, -1, 1, 2, 2, 2, 1, 1, 4};

   // returns wait count of the winning region, -1 for ROM
   function automatic int model_wait(input logic [10:0] s);
      for (int i = 0; i < 11; i++)
         if (!s[i]) return region_wait[i];
      return 8;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] rand_ds();
      logic [1:0] d;
      d = 2'($urandom_range(0, 2));
      return d;
   endfunction

   // One full bus cycle. ack_dly<0 means never acknowledge a ROM cycle.
   task automatic bus_cycle(input logic [10:0] s, input int ack_dly, input int hold);
      int w, exp_lat, exp_req, first_lo, req_hi;
      w = model_wait(s);
      if (w < 0) begin
         if (ack_dly < 0) begin
            exp_lat = 257; exp_req = 256; terr_model = 1'b1;
         end else begin
            exp_lat = ack_dly + 2; exp_req = ack_dly + 1;
         end
      end else begin
         exp_lat = (w == 0) ? 1 : w + 1; exp_req = 0;
      end
      @(negedge clk);
      cpu_as_n = 1'b0; cpu_ds_n = rand_ds(); sel = s;
      first_lo = -1; req_hi = 0;
      for (int c = 1; c <= 300 && first_lo < 0; c++) begin
         @(negedge clk);
         sel = 11'($urandom);
         if (c == 1) check("busy_start", int'(busy), 1);
         if (rom_req) req_hi++;
         if (!cpu_dtack_n) first_lo = c;
         rom_ack = (w < 0) && (c == ack_dly + 1) && (first_lo < 0);
      end
      rom_ack = 1'b0;
      check("dtack_latency", first_lo, exp_lat);
      check("rom_req_cycles", req_hi, exp_req);
      check("timeout_err", int'(timeout_err), int'(terr_model));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("dtack_hold", int'(cpu_dtack_n), 0);
      end
      cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
      @(negedge clk);
      check("dtack_release", int'(cpu_dtack_n), 1);
      check("busy_release", int'(busy), 0);
   endtask

   function automatic logic [10:0] rand_sel();
      logic [10:0] s;
      s = '1;
      if ($urandom_range(0, 3) != 0) begin
         s[$urandom_range(0, 10)] = 1'b0;
         if ($urandom_range(0, 2) == 0) s[$urandom_range(0, 10)] = 1'b0;
      end
      return s;
   endfunction

   initial begin
      logic [10:0] s;
      // reset state
      repeat (2) @(negedge clk);
      check("rst_dtack", int'(cpu_dtack_n), 1);
      check("rst_req", int'(rom_req), 0);
      check("rst_terr", int'(timeout_err), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;

      // directed: WORK, ROM with ack after 5, unmapped
      s = '1; s[4] = 1'b0; bus_cycle(s, 0, 1);
      s = '1; s[3] = 1'b0; bus_cycle(s, 4, 0);
      bus_cycle('1, 0, 2);

      // randomized cycles
      for (int n = 0; n < 30; n++) begin
         s = rand_sel();
         bus_cycle(s, $urandom_range(0, 20), $urandom_range(0, 3));
      end

      // SOUND cycle aborted at cycle 2: no DTACK
      @(negedge clk);
      s = '1; s[10] = 1'b0;
      cpu_as_n = 1'b0; cpu_ds_n = 2'b00; sel = s;
      @(negedge clk);
      @(negedge clk);
      cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_dtack", int'(cpu_dtack_n), 1);
      end
      s = '1; s[4] = 1'b0; bus_cycle(s, 0, 0);

      // ROM timeout, sticky flag afterwards
      s = '1; s[3] = 1'b0; bus_cycle(s, -1, 1);
      for (int n = 0; n < 6; n++) bus_cycle(rand_sel(), $urandom_range(0, 10), 1);

      // reset while ROM request is pending; late ack ignored
      @(negedge clk);
      s = '1; s[3] = 1'b0;
      cpu_as_n = 1'b0; cpu_ds_n = 2'b01; sel = s;
      repeat (3) @(negedge clk);
      check("pre_rst_req", int'(rom_req), 1);
      reset = 1'b1; cpu_as_n = 1'b1; cpu_ds_n = 2'b11;
      @(negedge clk);
      check("midrst_req", int'(rom_req), 0);
      check("midrst_dtack", int'(cpu_dtack_n), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_terr", int'(timeout_err), 0);
      terr_model = 1'b0;
      reset = 1'b0; rom_ack = 1'b1;
      @(negedge clk);
      rom_ack = 1'b0;
      @(negedge clk);
      check("late_ack_busy", int'(busy), 0);
      check("late_ack_dtack", int'(cpu_dtack_n), 1);
      check("late_ack_req", int'(rom_req), 0);
      s = '1; s[5] = 1'b0; bus_cycle(s, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
